// File: rtl/ultrasonic_ranger.sv
// -----------------------------------------------------------------------------
// ultrasonic_ranger
//
// Periodic ranging controller for an HC-SR04 style ultrasonic sensor. It pulses
// the trigger, times the echo pulse, converts the high time into whole
// centimetres and publishes the result. A new ranging cycle starts every
// PERIOD_CYC clocks while en is high.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   enables ranging; only looked at while idle
//   echo       in   raw asynchronous echo from the sensor
//   trig       out  registered sensor trigger pulse, TRIG_CYC clocks wide
//   dist_cm    out  last valid distance in cm (held between updates)
//   dist_valid out  one-cycle strobe when dist_cm has just been updated
//   timeout    out  the last cycle ended without a valid echo
//   busy       out  high whenever the controller is not idle
//   dbg_state  out  current FSM state, for debug and checkers
//
// dist_valid contract: dist_valid is a push-only strobe with no back-pressure.
// It is high for exactly one clock, in the same clock that dist_cm first shows
// the new value; the consumer must take it in that clock. dist_cm keeps its
// value until the next strobe (or reset).
//
// Assumes CYC_PER_CM >= 1, TRIG_CYC >= 1, TIMEOUT_CYC >= 1, PERIOD_CYC >= 2.
// -----------------------------------------------------------------------------
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYC    = 500,
  parameter int unsigned CYC_PER_CM  = 2900,
  parameter int unsigned TIMEOUT_CYC = 1_500_000,
  parameter int unsigned PERIOD_CYC  = 3_000_000,
  parameter int unsigned MAX_CM      = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] dist_cm,
  output logic       dist_valid,
  output logic       timeout,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLD      = 3'd4
  } state_t;

  // Fixed counter widths large enough for the default parameter maxima:
  // 22 bits covers 3_000_000, 12 bits covers 2899, 9 bits covers 400.
  localparam logic [21:0] TRIG_LAST   = 22'(TRIG_CYC - 1);
  localparam logic [21:0] TO_LAST     = 22'(TIMEOUT_CYC - 1);
  localparam logic [21:0] PERIOD_EXIT = 22'(PERIOD_CYC - 2);
  localparam logic [21:0] PERIOD_SAT  = '1;
  localparam logic [11:0] SUB_LAST    = 12'(CYC_PER_CM - 1);
  localparam logic [8:0]  CM_MAX      = 9'(MAX_CM);

  state_t      state;
  logic        echo_m;      // first synchroniser flop
  logic        echo_s;      // second synchroniser flop, the usable echo
  logic        echo_d;      // echo_s one clock earlier, for edge detection
  logic [1:0]  warm;        // clocks since reset release, saturates at 2
  logic [21:0] cnt;         // per-state timer (TRIG width / echo timeouts)
  logic [21:0] period_cnt;  // clocks since the current trigger started
  logic [11:0] sub_cnt;     // echo-high clocks within the current cm
  logic [8:0]  cm_cnt;      // whole centimetres accumulated so far

  logic echo_rise;
  assign echo_rise = echo_s & ~echo_d;

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Echo synchroniser plus one extra stage for rising-edge detection.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Start-up guard. The synchroniser flops come out of reset at 0, so for the
  // first two clocks echo_s does not yet reflect the pin. Triggering is held
  // off until it does; otherwise a sensor whose echo is stuck high would still
  // get one trigger right after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= 2'd0;
    end else if (warm != 2'd2) begin
      warm <= warm + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Ranging FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig       <= 1'b0;
      dist_cm    <= 9'd0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      cnt        <= 22'd0;
      period_cnt <= 22'd0;
      sub_cnt    <= 12'd0;
      cm_cnt     <= 9'd0;
    end else begin
      dist_valid <= 1'b0;

      // The period counter runs freely and is restarted on each trigger; it
      // saturates so an idle controller never wraps it.
      if (period_cnt != PERIOD_SAT) begin
        period_cnt <= period_cnt + 22'd1;
      end

      case (state)
        IDLE: begin
          if (warm == 2'd2 && en && !echo_s) begin
            state      <= TRIG;
            trig       <= 1'b1;
            busy       <= 1'b1;
            cnt        <= 22'd0;
            period_cnt <= 22'd0;
          end
        end

        TRIG: begin
          if (cnt == TRIG_LAST) begin
            state <= WAIT_ECHO;
            trig  <= 1'b0;
            cnt   <= 22'd0;
          end else begin
            cnt <= cnt + 22'd1;
          end
        end

        WAIT_ECHO: begin
          if (echo_rise) begin
            // The clock in which the rising edge is seen is already an
            // echo-high clock, so it is counted here; otherwise every
            // reading would come out one clock short.
            state <= MEASURE;
            cnt   <= 22'd0;
            if (SUB_LAST == 12'd0) begin
              sub_cnt <= 12'd0;
              cm_cnt  <= (CM_MAX != 9'd0) ? 9'd1 : 9'd0;
            end else begin
              sub_cnt <= 12'd1;
              cm_cnt  <= 9'd0;
            end
          end else if (cnt == TO_LAST) begin
            state   <= HOLD;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 22'd1;
          end
        end

        MEASURE: begin
          if (!echo_s) begin
            // Falling edge: publish the truncated cm count.
            state      <= HOLD;
            dist_cm    <= cm_cnt;
            dist_valid <= 1'b1;
            timeout    <= 1'b0;
          end else if (cnt == TO_LAST) begin
            // Echo too long: give up, keep the previous distance.
            state   <= HOLD;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 22'd1;
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= 12'd0;
              if (cm_cnt < CM_MAX) begin
                cm_cnt <= cm_cnt + 9'd1;
              end
            end else begin
              sub_cnt <= sub_cnt + 12'd1;
            end
          end
        end

        HOLD: begin
          // Leaving when the counter is at PERIOD_CYC-2 puts IDLE in the clock
          // where it reads PERIOD_CYC-1, so the next trigger rises exactly
          // PERIOD_CYC clocks after the previous one. The >= lets a cycle that
          // overran the period (both timeouts back to back) return at once.
          if (period_cnt >= PERIOD_EXIT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 Parameter TRIG_CYC, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter CYC_PER_CM, default 2900, echo-high cycles per centimetre of distance (58 us/cm at 50 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 1_500_000, max cycles waited in WAIT_ECHO and in MEASURE (30 ms).
REQ-004 Parameter PERIOD_CYC, default 3_000_000, cycles from one trigger start to the next (60 ms).
REQ-005 Parameter MAX_CM, default 400, saturation value of dist_cm.
REQ-006 Port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port en  input  1  enables ranging; sampled at IDLE.
REQ-009 Port echo  input  1  asynchronous sensor echo, synchronised internally.
REQ-010 Port trig  output  1  sensor trigger, registered.
REQ-011 Port dist_cm  output  9  last valid distance in whole cm, consumed by the display/valve stage.
REQ-012 Port dist_valid  output  1  one-cycle strobe on each new dist_cm.
REQ-013 Port timeout  output  1  last cycle ended without a valid echo.
REQ-014 Port busy  output  1  high in any state other than IDLE.

Function
REQ-015 echo SHALL pass a 2-flop synchroniser; echo_s denotes the second flop; all echo references below mean echo_s.
REQ-016 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD.
REQ-017 IDLE -> TRIG when en=1 and echo_s=0; otherwise stay.
REQ-018 TRIG: trig=1 for exactly TRIG_CYC cycles, then -> WAIT_ECHO; period counter clears to 0 on TRIG entry and counts every cycle thereafter.
REQ-019 WAIT_ECHO: echo_s rising -> MEASURE; TIMEOUT_CYC cycles without rising -> HOLD with timeout set.
REQ-020 MEASURE: sub-counter increments each cycle echo_s=1; on reaching CYC_PER_CM-1 it wraps to 0 and cm counter increments, saturating at MAX_CM.
REQ-021 MEASURE: echo_s falling -> dist_cm loads cm counter (truncated, no rounding), dist_valid=1 for one cycle, timeout cleared, -> HOLD.
REQ-022 MEASURE: echo_s still high after TIMEOUT_CYC cycles -> HOLD, timeout set, dist_cm unchanged, no dist_valid.
REQ-023 HOLD: wait until period counter reaches PERIOD_CYC-1, then -> IDLE.
REQ-024 dist_cm SHALL hold its value between strobes and on timeouts; timeout SHALL remain set until the next valid measurement.
REQ-025 en=0 SHALL only take effect in IDLE; a cycle in progress completes normally.
REQ-026 Latency: dist_valid asserts on the 3rd rising clk edge after the raw echo falling edge (2 sync + 1 register).
REQ-027 Counter widths SHALL hold their parameter maxima without wrap (period/timeout 22 bits, sub-counter 12 bits, cm 9 bits).
REQ-028 echo high at IDLE (sensor stuck) SHALL block triggering; trig stays 0.

Reset
REQ-029 While rst_n=0: state IDLE, trig=0, dist_cm=0, dist_valid=0, timeout=0, busy=0, all counters and synchroniser flops 0.
REQ-030 Reset asserted mid-cycle (any state) SHALL abort immediately; after release the first trigger starts no earlier than 1 cycle later.

Verification
REQ-031 en=1, echo high 29_000 cycles after trig -> one dist_valid, dist_cm=10, timeout=0.
REQ-032 echo high 2_899 cycles -> dist_cm=0 with dist_valid; echo high 5_800 cycles -> dist_cm=2.
REQ-033 echo high 1_400_000 cycles -> dist_cm=400 (saturated), dist_valid pulses once.
REQ-034 echo never rises -> timeout=1 exactly TRIG_CYC+TIMEOUT_CYC cycles after TRIG entry, dist_cm retains prior value, next trig 3_000_000 cycles after previous trig rise.
REQ-035 rst_n pulsed low mid-MEASURE -> all outputs 0 during reset, no dist_valid from the aborted cycle, normal ranging after release.
REQ-036 echo held high from reset release -> trig never asserts, busy=0; release echo -> trig asserts within 2 cycles + synchroniser delay.
